// File: rtl/bfp_converter_pkg.sv
// rtl/bfp_converter_pkg.sv - shared types and default widths for the BFP converter
package bfp_converter_pkg;

    localparam int DEF_MANTISSA_WIDTH = 6;
    localparam int DEF_EXPONENT_WIDTH = 8;
    localparam int DEF_GROUP_SIZE     = 8;
    localparam int IDX_WIDTH          = $clog2(DEF_GROUP_SIZE);

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

endpackage

// File: rtl/bfp_converter_group_buffer.sv
// rtl/bfp_converter_group_buffer.sv - one-group register file, one write and one read port
module bfp_converter_group_buffer
    import bfp_converter_pkg::*;
#(
    parameter int ENTRY_WIDTH = DEF_EXPONENT_WIDTH + DEF_MANTISSA_WIDTH,
    parameter int DEPTH       = DEF_GROUP_SIZE,
    parameter int ADDR_WIDTH  = IDX_WIDTH
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [ENTRY_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [ENTRY_WIDTH-1:0] rd_data
);

    logic [ENTRY_WIDTH-1:0] mem [DEPTH];

    // Contents need no reset: every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bfp_converter_shared_exponent.sv
// rtl/bfp_converter_shared_exponent.sv - groups elements, finds the shared max exponent, emits per-element diffs
module bfp_converter_shared_exponent
    import bfp_converter_pkg::*;
#(
    parameter int QUNATIZED_MANTISSA_WIDTH = DEF_MANTISSA_WIDTH,
    parameter int EXPONENT_WIDTH           = DEF_EXPONENT_WIDTH,
    parameter int GROUP_SIZE               = DEF_GROUP_SIZE
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [EXPONENT_WIDTH-1:0]           in_exponent,
    input  logic [QUNATIZED_MANTISSA_WIDTH-1:0] in_mantissa,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [QUNATIZED_MANTISSA_WIDTH-1:0] out_mantissa,
    output logic [EXPONENT_WIDTH-1:0]           out_exponent_diff,
    output logic [EXPONENT_WIDTH-1:0]           out_shared_exponent,
    output logic                                out_last
);

    localparam int CNT_WIDTH   = $clog2(GROUP_SIZE);
    localparam int ENTRY_WIDTH = EXPONENT_WIDTH + QUNATIZED_MANTISSA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(GROUP_SIZE - 1);

    state_t                          state, state_next;
    logic [CNT_WIDTH-1:0]            count, idx, rd_addr;
    logic [EXPONENT_WIDTH-1:0]       max_q, in_max, rd_exponent;
    logic [QUNATIZED_MANTISSA_WIDTH-1:0] rd_mantissa;
    logic [ENTRY_WIDTH-1:0]          rd_data;
    logic                            in_fire, out_fire, last_in;

    bfp_converter_group_buffer #(
        .ENTRY_WIDTH (ENTRY_WIDTH),
        .DEPTH       (GROUP_SIZE),
        .ADDR_WIDTH  (CNT_WIDTH)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (in_fire),
        .wr_addr (count),
        .wr_data ({in_exponent, in_mantissa}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign {rd_exponent, rd_mantissa} = rd_data;

    always_comb begin
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        last_in    = in_fire && (count == LAST_IDX);
        in_max     = (count == '0 || in_exponent > max_q) ? in_exponent : max_q;
        // Element 0 is prefetched while collecting; in EMIT the next element is staged.
        rd_addr    = (state == EMIT) ? idx + CNT_WIDTH'(1) : '0;
        state_next = state;
        case (state)
            COLLECT: if (last_in) state_next = EMIT;
            EMIT:    if (out_fire && out_last) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count               <= '0;
            idx                 <= '0;
            max_q               <= '0;
            in_ready            <= 1'b0;
            out_valid           <= 1'b0;
            out_mantissa        <= '0;
            out_exponent_diff   <= '0;
            out_shared_exponent <= '0;
            out_last            <= 1'b0;
        end else begin
            in_ready <= (state_next == COLLECT);
            if (in_fire) begin
                count <= last_in ? '0 : count + CNT_WIDTH'(1);
                max_q <= in_max;
            end
            // The final input completes the max, so element 0 uses in_max directly.
            if (last_in) begin
                idx                 <= '0;
                out_valid           <= 1'b1;
                out_mantissa        <= rd_mantissa;
                out_exponent_diff   <= in_max - rd_exponent;
                out_shared_exponent <= in_max;
                out_last            <= 1'b0;
            end else if (out_fire) begin
                if (out_last) begin
                    idx       <= '0;
                    out_valid <= 1'b0;
                end else begin
                    idx               <= rd_addr;
                    out_mantissa      <= rd_mantissa;
                    out_exponent_diff <= max_q - rd_exponent;
                    out_last          <= (rd_addr == LAST_IDX);
                end
            end
        end
    end

endmodule
